conv_window_sched: RTL and testbench
====================================

// Module: conv_window_sched
// PURPOSE
//  Sequences the 5x5, 8-filter convolution datapath over one image frame.
//  Streams N_FILT*K*K weights into the datapath weight store, then raster-scans every valid window top-left.
//  Raster order is IMG_H-K+1 rows x IMG_W-K+1 cols (24x24 = 576 at defaults).
//  Returns results through a valid/ready handshake; backpressure stalls the scan.
//  Sits between the frame/weight loaders and the convolution datapath.
// PARAMETERS
//  IMG_W     28  image width (pixels)
//  IMG_H     28  image height (pixels)
//  K         5   kernel edge; taps per filter = K*K
//  N_FILT    8   filters sharing the datapath
//  WEIGHT_W  32  signed weight width
// PORTS
//  clk         in   1                    clock, rising edge
//  rst_n       in   1                    asynchronous, active-low reset
//  start       in   1                    1-cycle pulse; begins weight load + scan; ignored unless IDLE
//  busy        out  1                    high in LOAD, RUN, DRAIN
//  done        out  1                    1-cycle pulse after last result accepted
//  wgt_valid   in   1                    weight stream valid
//  wgt_data    in   WEIGHT_W             weight word, filter-major, tap raster order
//  wgt_ready   out  1                    high only in LOAD
//  wgt_we      out  1                    datapath weight write strobe (= wgt_valid & wgt_ready)
//  wgt_filt    out  $clog2(N_FILT)       filter index of current write
//  wgt_tap     out  $clog2(K*K)          tap index (row*K+col) of current write
//  wgt_wdata   out  WEIGHT_W             = wgt_data (combinational pass-through)
//  win_valid   out  1                    window coordinates presented to datapath this cycle
//  win_row     out  $clog2(IMG_H)        window top-left row
//  win_col     out  $clog2(IMG_W)        window top-left column
//  res_valid   out  1                    datapath result register holds result for res_row/res_col
//  res_row     out  $clog2(IMG_H)        output row of presented result
//  res_col     out  $clog2(IMG_W)        output column of presented result
//  res_ready   in   1                    consumer accepts result
// BEHAVIOUR
//  Reset: state IDLE; all outputs 0; counters 0.
//  FSM transitions:
//   IDLE  -start-> LOAD
//   LOAD  -> RUN on handshake with filt=N_FILT-1, tap=K*K-1
//   RUN   -> DRAIN when last window issued
//   DRAIN -> DONE when last result accepted
//   DONE  -> IDLE after 1 cycle; done=1 only in DONE
//  LOAD: tap increments per handshake; on tap=K*K-1 wraps to 0 and filt+1. Exactly N_FILT*K*K (200) writes; gaps in wgt_valid allowed.
//  RUN issue rule: adv = !res_valid | res_ready.
//   win_valid=1 throughout RUN.
//   On adv: col+1; at col=IMG_W-K, col wraps to 0 and row+1.
//   Last window is (IMG_H-K, IMG_W-K).
//  Latency: window issued (adv) at cycle t -> res_valid=1 at t+1, res_row/col = that window.
//   Matches datapath 1-cycle registered result.
//  Stall: res_valid & !res_ready -> win_row/col and res_row/col held; held window recomputes identical result.
//  res_valid clears on accept when no new window issued (DRAIN).
//  Throughput: 1 result/cycle with res_ready=1; 576 results, first at RUN+1.
//  start while busy: ignored, no effect on counters.
//  rst_n low mid-frame: immediate return to IDLE, outputs 0, partial results discarded; next start reloads all weights.
// CONFIGURATION
//  WSCHED_PERF_CNT_EN defined:
//   Adds output stall_cycles [31:0].
//   Counts cycles with res_valid & !res_ready in RUN/DRAIN.
//   Saturates at 32'hFFFF_FFFF; cleared on accepted start; reset 0.
//  Undefined: port and counter absent; all other behaviour identical.
// TESTING
//  T1 Reset: rst_n=0 during RUN -> next cycle busy=0, win_valid=0, res_valid=0, state IDLE.
//  T2 Load: start, 200 weights with wgt_valid random 50% ->
//     exactly 200 wgt_we; last at filt=7, tap=24; RUN begins next cycle.
//  T3 Full frame, res_ready=1: 576 results, rows/cols 0..23 raster ->
//     last res (23,23); done pulse 2 cycles after last issue; 576 consecutive res_valid cycles.
//  T4 Backpressure: res_ready=0 for 10 cycles at result (3,7) ->
//     res_row/col held (3,7), win held (3,8); no result lost or duplicated;
//     with WSCHED_PERF_CNT_EN, stall_cycles=10.
//  T5 start pulses during LOAD and RUN -> ignored; frame still yields exactly 576 results and one done.
//  T6 Back-to-back frames: start in cycle after done -> second full load + 576 results; stall_cycles cleared to 0.

Source files
------------

// File: rtl/conv_window_sched_if.sv
`default_nettype none
// ============================================================================
//  Module   : conv_window_sched_if
//  Purpose  : Bundles the weight-stream, window-issue and result handshake
//             signals between conv_window_sched and its neighbours.
//  Modports : master - scheduler side (drives ready/strobes/coordinates)
//             slave  - loader/datapath/consumer side
//  Signals  : wgt_valid/wgt_data/wgt_ready    weight stream handshake
//             wgt_we/wgt_filt/wgt_tap/wgt_wdata weight store write port
//             win_valid/win_row/win_col        window issue to datapath
//             res_valid/res_row/res_col/res_ready result handshake
//  Revision : 1.0 - initial release
// ============================================================================
interface conv_window_sched_if #(
    parameter int IMG_W    = 28,
    parameter int IMG_H    = 28,
    parameter int K        = 5,
    parameter int N_FILT   = 8,
    parameter int WEIGHT_W = 32
);
    localparam int FILT_W = (N_FILT > 1) ? $clog2(N_FILT) : 1;
    localparam int TAP_W  = $clog2(K * K);
    localparam int ROW_W  = $clog2(IMG_H);
    localparam int COL_W  = $clog2(IMG_W);

    logic                wgt_valid;
    logic [WEIGHT_W-1:0] wgt_data;
    logic                wgt_ready;
    logic                wgt_we;
    logic [FILT_W-1:0]   wgt_filt;
    logic [TAP_W-1:0]    wgt_tap;
    logic [WEIGHT_W-1:0] wgt_wdata;
    logic                win_valid;
    logic [ROW_W-1:0]    win_row;
    logic [COL_W-1:0]    win_col;
    logic                res_valid;
    logic [ROW_W-1:0]    res_row;
    logic [COL_W-1:0]    res_col;
    logic                res_ready;

    modport master (
        input  wgt_valid, wgt_data, res_ready,
        output wgt_ready, wgt_we, wgt_filt, wgt_tap, wgt_wdata,
               win_valid, win_row, win_col, res_valid, res_row, res_col
    );

    modport slave (
        output wgt_valid, wgt_data, res_ready,
        input  wgt_ready, wgt_we, wgt_filt, wgt_tap, wgt_wdata,
               win_valid, win_row, win_col, res_valid, res_row, res_col
    );
endinterface
`default_nettype wire

// File: rtl/conv_window_sched.sv
`default_nettype none
// ============================================================================
//  Module   : conv_window_sched
//  Purpose  : Sequences a KxK, N_FILT-filter convolution datapath over one
//             frame: streams N_FILT*K*K weights into the weight store, then
//             raster-scans every valid window top-left, returning results
//             through a valid/ready handshake (backpressure stalls the scan).
//  Ports    : clk          clock, rising edge
//             rst_n        asynchronous active-low reset
//             start        1-cycle pulse, accepted only when idle
//             busy         high while loading, scanning or draining
//             done         1-cycle pulse after the last result is accepted
//             stall_cycles result-stall counter (WSCHED_PERF_CNT_EN only)
//             bus          conv_window_sched_if.master (weights/windows/results)
//  Config   : `define WSCHED_PERF_CNT_EN adds the stall_cycles counter/port.
//  Revision : 1.0 - initial release
// ============================================================================
module conv_window_sched #(
    parameter int IMG_W    = 28,
    parameter int IMG_H    = 28,
    parameter int K        = 5,
    parameter int N_FILT   = 8,
    parameter int WEIGHT_W = 32
) (
    input  wire logic   clk,
    input  wire logic   rst_n,
    input  wire logic   start,
    output logic        busy,
    output logic        done,
`ifdef WSCHED_PERF_CNT_EN
    output logic [31:0] stall_cycles,
`endif
    conv_window_sched_if.master bus
);
    localparam int FILT_W = (N_FILT > 1) ? $clog2(N_FILT) : 1;
    localparam int TAP_W  = $clog2(K * K);
    localparam int ROW_W  = $clog2(IMG_H);
    localparam int COL_W  = $clog2(IMG_W);

    localparam logic [FILT_W-1:0] c_FILT_LAST = FILT_W'(N_FILT - 1);
    localparam logic [TAP_W-1:0]  c_TAP_LAST  = TAP_W'(K * K - 1);
    localparam logic [ROW_W-1:0]  c_ROW_LAST  = ROW_W'(IMG_H - K);
    localparam logic [COL_W-1:0]  c_COL_LAST  = COL_W'(IMG_W - K);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_RUN   = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;

    logic [FILT_W-1:0]   r_filt;
    logic [TAP_W-1:0]    r_tap;
    logic [ROW_W-1:0]    r_row;
    logic [COL_W-1:0]    r_col;
    logic                r_res_valid;
    logic [ROW_W-1:0]    r_res_row;
    logic [COL_W-1:0]    r_res_col;

    logic                w_start_acc;
    logic                w_wgt_hs;
    logic                w_wgt_last;
    logic                w_adv;
    logic                w_win_last;
    logic                w_res_acc;
    logic [WEIGHT_W-1:0] w_wdata;

    assign w_start_acc = start & (r_state == S_IDLE);
    assign w_wgt_hs    = bus.wgt_valid & (r_state == S_LOAD);
    assign w_wgt_last  = w_wgt_hs & (r_filt == c_FILT_LAST) & (r_tap == c_TAP_LAST);
    // A new window may be issued whenever the result register is free or
    // is being emptied this cycle; otherwise the scan holds in place.
    assign w_adv       = (r_state == S_RUN) & (~r_res_valid | bus.res_ready);
    assign w_win_last  = (r_row == c_ROW_LAST) & (r_col == c_COL_LAST);
    assign w_res_acc   = r_res_valid & bus.res_ready;

    assign w_wdata       = bus.wgt_data;
    assign bus.wgt_wdata = w_wdata;
    assign bus.wgt_we    = w_wgt_hs;
    assign bus.wgt_filt  = r_filt;
    assign bus.wgt_tap   = r_tap;
    assign bus.win_row   = r_row;
    assign bus.win_col   = r_col;
    assign bus.res_valid = r_res_valid;
    assign bus.res_row   = r_res_row;
    assign bus.res_col   = r_res_col;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and state-decoded outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt   = r_state;
        busy          = 1'b0;
        done          = 1'b0;
        bus.wgt_ready = 1'b0;
        bus.win_valid = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = S_LOAD;
                end
            end
            S_LOAD: begin
                busy          = 1'b1;
                bus.wgt_ready = 1'b1;
                if (w_wgt_last) begin
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                busy          = 1'b1;
                bus.win_valid = 1'b1;
                if (w_adv && w_win_last) begin
                    w_state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                busy = 1'b1;
                if (w_res_acc) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                done        = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Weight write address: tap raster within a filter, filter-major
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_filt <= '0;
            r_tap  <= '0;
        end else if (w_start_acc) begin
            r_filt <= '0;
            r_tap  <= '0;
        end else if (w_wgt_hs) begin
            if (r_tap == c_TAP_LAST) begin
                r_tap <= '0;
                if (r_filt == c_FILT_LAST) begin
                    r_filt <= '0;
                end else begin
                    r_filt <= r_filt + 1'b1;
                end
            end else begin
                r_tap <= r_tap + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Window scan counters; wrap to origin after the last window so the
    // next frame starts clean even without an explicit clear.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_row <= '0;
            r_col <= '0;
        end else if (w_start_acc) begin
            r_row <= '0;
            r_col <= '0;
        end else if (w_adv) begin
            if (r_col == c_COL_LAST) begin
                r_col <= '0;
                if (r_row == c_ROW_LAST) begin
                    r_row <= '0;
                end else begin
                    r_row <= r_row + 1'b1;
                end
            end else begin
                r_col <= r_col + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Result tag tracks the datapath's one-cycle registered result: the
    // coordinates of the window issued last cycle.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_res_valid <= 1'b0;
            r_res_row   <= '0;
            r_res_col   <= '0;
        end else if (w_start_acc) begin
            r_res_valid <= 1'b0;
            r_res_row   <= '0;
            r_res_col   <= '0;
        end else if (w_adv) begin
            r_res_valid <= 1'b1;
            r_res_row   <= r_row;
            r_res_col   <= r_col;
        end else if (w_res_acc) begin
            r_res_valid <= 1'b0;
        end
    end

`ifdef WSCHED_PERF_CNT_EN
    // ------------------------------------------------------------------
    // Saturating count of cycles a result waits on the consumer
    // ------------------------------------------------------------------
    logic [31:0] r_stall_cycles;
    logic        w_stall;

    assign w_stall = ((r_state == S_RUN) | (r_state == S_DRAIN)) & r_res_valid & ~bus.res_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cycles <= '0;
        end else if (w_start_acc) begin
            r_stall_cycles <= '0;
        end else if (w_stall && (r_stall_cycles != 32'hFFFF_FFFF)) begin
            r_stall_cycles <= r_stall_cycles + 32'd1;
        end
    end

    assign stall_cycles = r_stall_cycles;
`endif

endmodule
`default_nettype wire

// File: tb/tb_conv_window_sched.sv
`default_nettype none
// ============================================================================
//  Module   : tb_conv_window_sched
//  Purpose  : Self-checking bench for conv_window_sched. A count-based
//             frame model (weights written, windows issued, results
//             accepted) predicts every output each cycle; per-frame literal
//             checks pin load length, scan end, done timing and stalls.
//  Config   : honours `define WSCHED_PERF_CNT_EN (checks stall_cycles).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_conv_window_sched;
    localparam int IMG_W    = 28;
    localparam int IMG_H    = 28;
    localparam int K        = 5;
    localparam int N_FILT   = 8;
    localparam int WEIGHT_W = 32;
    localparam int NW       = N_FILT * K * K;
    localparam int OW       = IMG_W - K + 1;
    localparam int OH       = IMG_H - K + 1;
    localparam int NWIN     = OW * OH;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic busy;
    logic done;
`ifdef WSCHED_PERF_CNT_EN
    logic [31:0] stall_cycles;
`endif

    conv_window_sched_if #(
        .IMG_W(IMG_W), .IMG_H(IMG_H), .K(K), .N_FILT(N_FILT), .WEIGHT_W(WEIGHT_W)
    ) bus ();

    conv_window_sched #(
        .IMG_W(IMG_W), .IMG_H(IMG_H), .K(K), .N_FILT(N_FILT), .WEIGHT_W(WEIGHT_W)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .busy         (busy),
        .done         (done),
`ifdef WSCHED_PERF_CNT_EN
        .stall_cycles (stall_cycles),
`endif
        .bus          (bus)
    );

    always #5 clk = ~clk;

    // ---------------- check bookkeeping (written by monitor only) --------
    int n_checks = 0;
    int n_err    = 0;

    task automatic chk(input string nm, input longint act, input longint exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- frame expectations (written by main only) ----------
    bit exp_full_tp    = 0;
    bit exp_ready_full = 0;
    bit exp_stall10    = 0;
    bit in_stall       = 0;
    bit timeout_flag   = 0;

    // ---------------- behavioural model state ----------------------------
    int m_wc, m_iss, m_acc, m_stall;
    bit m_active, m_done;

    // ---------------- per-frame statistics -------------------------------
    int cyc;
    int st_we, st_last_filt, st_last_tap, st_last_we_cyc;
    int st_last_issue_cyc, st_res_run, st_max_run, st_acc, st_last_rr, st_last_rc;
    bit st_run_seen, timeout_seen;

    function automatic void clear_stats();
        st_we = 0; st_last_filt = -1; st_last_tap = -1; st_last_we_cyc = -1;
        st_last_issue_cyc = -1; st_res_run = 0; st_max_run = 0;
        st_acc = 0; st_last_rr = -1; st_last_rc = -1; st_run_seen = 0;
    endfunction

    // ---------------- monitor / compare process --------------------------
    initial begin
        bit e_load, e_run, e_drain, e_rv, adv, acc;
        cyc = 0; timeout_seen = 0;
        m_wc = 0; m_iss = 0; m_acc = 0; m_stall = 0; m_active = 0; m_done = 0;
        clear_stats();
        forever begin
            @(negedge clk);
            cyc++;
            if (timeout_flag && !timeout_seen) begin
                timeout_seen = 1;
                chk("bound_expired", timeout_flag, 0);
            end
            if (!rst_n) begin
                chk("rst_ctrl_outputs", {busy, done, bus.wgt_ready, bus.wgt_we,
                                         bus.win_valid, bus.res_valid}, 0);
                chk("rst_coord_outputs", {bus.win_row, bus.win_col, bus.res_row,
                                          bus.res_col, bus.wgt_filt, bus.wgt_tap}, 0);
`ifdef WSCHED_PERF_CNT_EN
                chk("rst_stall_cycles", stall_cycles, 0);
`endif
                m_wc = 0; m_iss = 0; m_acc = 0; m_stall = 0; m_active = 0; m_done = 0;
                clear_stats();
            end else begin
                // ---- model prediction for this cycle ----
                e_load  = m_active && (m_wc < NW);
                e_run   = m_active && (m_wc == NW) && (m_iss < NWIN);
                e_drain = m_active && (m_iss == NWIN);
                e_rv    = (m_iss > m_acc);
                chk("busy", busy, e_load | e_run | e_drain);
                chk("done", done, m_done);
                chk("wgt_ready", bus.wgt_ready, e_load);
                chk("wgt_we", bus.wgt_we, e_load & bus.wgt_valid);
                chk("wgt_wdata", bus.wgt_wdata, bus.wgt_data);
                chk("win_valid", bus.win_valid, e_run);
                chk("res_valid", bus.res_valid, e_rv);
                if (e_load && bus.wgt_valid) begin
                    chk("wgt_filt", bus.wgt_filt, m_wc / (K * K));
                    chk("wgt_tap", bus.wgt_tap, m_wc % (K * K));
                end
                if (e_run) begin
                    chk("win_row", bus.win_row, m_iss / OW);
                    chk("win_col", bus.win_col, m_iss % OW);
                end
                if (e_rv) begin
                    chk("res_row", bus.res_row, m_acc / OW);
                    chk("res_col", bus.res_col, m_acc % OW);
                end
`ifdef WSCHED_PERF_CNT_EN
                chk("stall_cycles", stall_cycles, m_stall);
`endif
                // ---- literal pins on held window during the forced stall ----
                if (in_stall) begin
                    chk("stall_res_pos", {bus.res_valid, 3'b0, bus.res_row, 3'b0, bus.res_col},
                        {1'b1, 8'd3, 8'd7});
                    chk("stall_win_pos", {3'b0, bus.win_row, 3'b0, bus.win_col}, {8'd3, 8'd8});
                end

                // ---- statistics from observed DUT behaviour ----
                if (bus.wgt_we) begin
                    st_we++; st_last_filt = int'(bus.wgt_filt);
                    st_last_tap = int'(bus.wgt_tap); st_last_we_cyc = cyc;
                end
                if (bus.win_valid && !st_run_seen) begin
                    st_run_seen = 1;
                    chk("load_write_count", st_we, NW);
                    chk("load_last_filt", st_last_filt, N_FILT - 1);
                    chk("load_last_tap", st_last_tap, K * K - 1);
                    chk("run_follows_load", cyc - st_last_we_cyc, 1);
                end
                if (bus.win_valid && (!bus.res_valid || bus.res_ready))
                    st_last_issue_cyc = cyc;
                if (bus.res_valid) begin
                    st_res_run++;
                    if (st_res_run > st_max_run) st_max_run = st_res_run;
                end else begin
                    st_res_run = 0;
                end
                if (bus.res_valid && bus.res_ready) begin
                    st_acc++; st_last_rr = int'(bus.res_row); st_last_rc = int'(bus.res_col);
                end
                if (done) begin
                    chk("frame_result_count", st_acc, 576);
                    chk("frame_last_result", st_last_rr * 100 + st_last_rc, 2323);
                    if (exp_ready_full)
                        chk("done_after_last_issue", cyc - st_last_issue_cyc, 2);
                    if (exp_full_tp)
                        chk("consecutive_res_valid", st_max_run, 576);
`ifdef WSCHED_PERF_CNT_EN
                    if (exp_stall10)
                        chk("stall_cycles_total", stall_cycles, 10);
`endif
                end

                // ---- advance model across the coming edge ----
                adv = e_run && (!e_rv || bus.res_ready);
                acc = e_rv && bus.res_ready;
                if ((e_run || e_drain) && e_rv && !bus.res_ready) m_stall++;
                if (e_load && bus.wgt_valid) m_wc++;
                if (adv) m_iss++;
                if (acc) m_acc++;
                if (m_done) begin
                    m_done = 0;
                end else if (acc && m_acc == NWIN) begin
                    m_done = 1; m_active = 0;
                end else if (start && !m_active) begin
                    m_active = 1; m_wc = 0; m_iss = 0; m_acc = 0; m_stall = 0;
                    clear_stats();
                end
            end
        end
    end

    // ---------------- stimulus ------------------------------------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_frame(input int vpct, input int rpct, input bit stall37,
                             input bit spur, input bit full_tp);
        bit got = 0;
        bit stall_used = 0;
        int stall_left = 0;
        exp_full_tp = full_tp; exp_stall10 = stall37; exp_ready_full = (rpct == 100);
        start = 1; bus.res_ready = 1'b1;
        step();
        start = 0;
        for (int c = 0; c < 6000 && !got; c++) begin
            bus.wgt_valid = (($urandom % 100) < vpct);
            bus.wgt_data  = $urandom;
            if (stall37 && !stall_used && bus.res_valid &&
                bus.res_row == 5'd3 && bus.res_col == 5'd7) begin
                stall_left = 10; stall_used = 1;
            end
            if (stall_left > 0) begin
                bus.res_ready = 1'b0; in_stall = 1; stall_left--;
            end else begin
                in_stall = 0; bus.res_ready = (($urandom % 100) < rpct);
            end
            start = spur ? (($urandom % 16) == 0) : 1'b0;
            step();
            if (done) got = 1;
        end
        in_stall = 0; start = 0; bus.wgt_valid = 1'b0; bus.res_ready = 1'b1;
        if (!got) timeout_flag = 1;
        step();
    endtask

    task automatic reset_mid_run();
        bit seen = 0;
        start = 1; bus.res_ready = 1'b1;
        step();
        start = 0;
        for (int c = 0; c < 2000 && !seen; c++) begin
            bus.wgt_valid = 1'b1; bus.wgt_data = $urandom;
            step();
            if (bus.win_valid) seen = 1;
        end
        bus.wgt_valid = 1'b0;
        if (!seen) timeout_flag = 1;
        repeat (30) step();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        step();
    endtask

    initial begin
        bus.wgt_valid = 1'b0;
        bus.wgt_data  = '0;
        bus.res_ready = 1'b0;
        repeat (3) step();
        rst_n = 1'b1;
        step();
        run_frame(50, 100, 1'b0, 1'b0, 1'b1);  // load with gaps + full-rate frame
        run_frame(100, 100, 1'b1, 1'b0, 1'b0); // 10-cycle stall at result (3,7)
        run_frame(70, 60, 1'b0, 1'b1, 1'b0);   // random backpressure + stray starts
        run_frame(100, 100, 1'b0, 1'b0, 1'b1); // back-to-back, counter cleared
        reset_mid_run();                        // abort during scan
        run_frame(60, 100, 1'b0, 1'b1, 1'b1);  // full reload after reset
        repeat (3) step();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule
`default_nettype wire
